game_sequencer: RTL
===================

Name: game_sequencer

Overview:
- Frame-level game controller sitting beside the VGA controller, ship, bullets and enemies blocks in the top-level.
- Watches per-pixel overlap of ship, enemy and bullet layers during each visible frame. Evaluates collisions once per frame on the calc strobe.
- Sequences the game through attract, play, respawn and game-over, and owns score and lives.
- Gates movement of the sprite blocks (run) and requests enemy-wave reinitialisation (wave_clear).

Parameters:
- LIVES, 3, lives granted at game start; legal range 1..7.
- POINTS, 10, score added per frame with at least one bullet/enemy overlap.
- RESPAWN_FRAMES, 120, frames spent in HIT before returning to PLAY; must be >= 1.
- GAMEOVER_FRAMES, 180, frames spent in OVER before auto-return to IDLE; must be >= 1.

Ports:
- clock  in  1  system pixel clock (100 MHz).
- reset  in  1  synchronous, active-high.
- calc  in  1  one-cycle frame strobe from the VGA controller, asserted once per frame outside the visible area.
- visible  in  1  current pixel is in the active area.
- ship_px  in  1  ship layer opaque at current pixel (ship_color[0]).
- enemy_px  in  1  enemy layer opaque at current pixel (enemy_color[0]).
- bullet_px  in  1  bullet layer opaque at current pixel (bullet_color[0]).
- start  in  1  level input from the Wii controller start button, already synchronous to clock.
- game_state  out  2  current state code.
- run  out  1  high only in PLAY; sprite blocks freeze motion when low.
- wave_clear  out  1  one-cycle pulse: reset enemies/bullets to initial wave.
- score  out  16  binary score, saturating.
- lives  out  3  remaining lives.
- led  out  10  status: [9:8]=game_state, [7]=run, [6:0]=lives thermometer (bit i set iff lives>i).

Behaviour:
- Reset (synchronous, any cycle, mid-frame or mid-state): state=IDLE, score=0, lives=0, run=0, wave_clear=0, led=0, all sticky flags and counters cleared.
- Sticky flags. On any cycle with visible=1 and calc=0:
  - ship_hit |= ship_px & enemy_px
  - bullet_hit |= bullet_px & enemy_px
  - Pixels on a calc cycle are ignored.
- Start edge. start_q registers start. A rising edge (start & ~start_q) sets start_pend.
- On each calc cycle:
  - The FSM evaluates using the flag and start_pend values as registered before that edge.
  - ship_hit, bullet_hit and start_pend are cleared on the same edge.
  - A start edge coinciding with calc is dropped.
- All state/score/lives updates occur only on calc edges, so results are visible 1 cycle after the calc cycle.
- IDLE:
  - start_pend → PLAY; lives=LIVES, score=0, wave_clear=1 for exactly the next cycle.
  - Otherwise stay in IDLE.
- PLAY (run=1):
  - If bullet_hit: score = min(score+POINTS, 16'hFFFF).
  - If ship_hit and lives>1: lives-=1, frame_cnt=0 → HIT.
  - If ship_hit and lives==1: lives=0, frame_cnt=0 → OVER.
  - Simultaneous ship_hit and bullet_hit: the score still updates and the ship hit still takes effect.
  - start is ignored.
- HIT (run=0):
  - frame_cnt increments per calc.
  - When frame_cnt==RESPAWN_FRAMES-1: → PLAY, wave_clear pulse, frame_cnt=0.
  - Collisions are ignored.
- OVER (run=0):
  - frame_cnt increments per calc.
  - start_pend, or frame_cnt==GAMEOVER_FRAMES-1 → IDLE, frame_cnt=0.
  - score and lives are held until the next game start.
- run is registered and equals (state==PLAY), updating on the same edge as state.
- wave_clear is never high for 2 consecutive cycles.
- frame_cnt is 8 bits; the parameters must be ≤ 256.
- led is a combinational decode of registered state/run/lives.

Decomposition:
- Shared package game_pkg:
  - state codes IDLE=2'd0, PLAY=2'd1, HIT=2'd2, OVER=2'd3.
  - SCORE_W=16, LIVES_W=3.
  - Also used by the top-level pixel mux and future HUD block.
- One sub-module, frame_collision_latch: the sticky flags and start edge/pending logic, cleared on calc.
- The FSM, counters and score arithmetic stay in game_sequencer.

Test Plan:
- Reset mid-PLAY, then start rising edge, then calc → game_state=1, lives=3, score=0, wave_clear high exactly 1 cycle, led=10'b01_1_0000111.
- In PLAY, one frame with bullet_px&enemy_px overlapping for 50 pixels → score=10 after calc (not 500). A frame with overlap only on the calc cycle or with visible=0 → score unchanged.
- In PLAY with lives=3, a frame with ship_px&enemy_px overlap plus bullet overlap → lives=2, score+10, state=HIT, run=0. After exactly 120 calcs → PLAY with a wave_clear pulse.
- Three ship hits (with respawns between) → third hit gives lives=0, state=OVER. With no start, after 180 calcs → IDLE, score retained.
- Score preset near saturation (65530) plus a bullet hit frame → score=65535. A further hit frame keeps 65535.
- start edges: held-high start produces a single edge; an edge in the same cycle as calc is dropped (stays IDLE); a start edge during OVER returns to IDLE at the next calc.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state codes, widths and status helpers
package game_pkg;

  localparam int SCORE_W = 16;
  localparam int LIVES_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  // Bit i is set while more than i lives remain.
  function automatic logic [6:0] lives_thermo(input logic [LIVES_W-1:0] n);
    logic [6:0] t;
    for (int i = 0; i < 7; i++) begin
      t[i] = (int'(n) > i);
    end
    return t;
  endfunction

endpackage

// File: rtl/frame_collision_latch.sv
// rtl/frame_collision_latch.sv - per-frame sticky overlap flags and start-edge pending bit
module frame_collision_latch (
  input  logic clock,
  input  logic reset,
  input  logic calc,
  input  logic visible,
  input  logic ship_px,
  input  logic enemy_px,
  input  logic bullet_px,
  input  logic start,
  output logic ship_hit,
  output logic bullet_hit,
  output logic start_pend
);

  logic start_q;

  // calc clears everything, so pixels and start edges on the calc cycle are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q    <= 1'b0;
      ship_hit   <= 1'b0;
      bullet_hit <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      start_q <= start;
      if (calc) begin
        ship_hit   <= 1'b0;
        bullet_hit <= 1'b0;
        start_pend <= 1'b0;
      end else begin
        if (visible && ship_px && enemy_px) ship_hit <= 1'b1;
        if (visible && bullet_px && enemy_px) bullet_hit <= 1'b1;
        if (start && !start_q) start_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - frame-level game FSM owning score, lives, run gating and wave reinit
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int POINTS          = 10,
  parameter int RESPAWN_FRAMES  = 120,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               calc,
  input  logic               visible,
  input  logic               ship_px,
  input  logic               enemy_px,
  input  logic               bullet_px,
  input  logic               start,
  output logic [1:0]         game_state,
  output logic               run,
  output logic               wave_clear,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [9:0]         led
);

  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] OVER_LAST    = 8'(GAMEOVER_FRAMES - 1);

  logic ship_hit, bullet_hit, start_pend;

  frame_collision_latch u_latch (
    .clock      (clock),
    .reset      (reset),
    .calc       (calc),
    .visible    (visible),
    .ship_px    (ship_px),
    .enemy_px   (enemy_px),
    .bullet_px  (bullet_px),
    .start      (start),
    .ship_hit   (ship_hit),
    .bullet_hit (bullet_hit),
    .start_pend (start_pend)
  );

  game_state_t        state_q, state_d;
  logic [SCORE_W-1:0] score_d;
  logic [LIVES_W-1:0] lives_d;
  logic [7:0]         frame_cnt, cnt_d;
  logic               wave_d;
  logic [SCORE_W:0]   score_sum;

  assign score_sum = {1'b0, score} + (SCORE_W + 1)'(POINTS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      score      <= '0;
      lives      <= '0;
      frame_cnt  <= '0;
      run        <= 1'b0;
      wave_clear <= 1'b0;
    end else begin
      state_q    <= state_d;
      score      <= score_d;
      lives      <= lives_d;
      frame_cnt  <= cnt_d;
      run        <= (state_d == PLAY);
      wave_clear <= wave_d;
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score;
    lives_d = lives;
    cnt_d   = frame_cnt;
    wave_d  = 1'b0;
    if (calc) begin
      unique case (state_q)
        IDLE: begin
          if (start_pend) begin
            state_d = PLAY;
            lives_d = LIVES_W'(LIVES);
            score_d = '0;
            wave_d  = 1'b1;
          end
        end
        PLAY: begin
          if (bullet_hit) score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          if (ship_hit) begin
            cnt_d = '0;
            if (lives > LIVES_W'(1)) begin
              lives_d = lives - LIVES_W'(1);
              state_d = HIT;
            end else begin
              lives_d = '0;
              state_d = OVER;
            end
          end
        end
        HIT: begin
          if (frame_cnt == RESPAWN_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
            wave_d  = 1'b1;
          end else begin
            cnt_d = frame_cnt + 8'd1;
          end
        end
        OVER: begin
          if (start_pend || frame_cnt == OVER_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = frame_cnt + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Guarantees a single-cycle pulse even if calc were asserted back to back.
    wave_d = wave_d & ~wave_clear;
  end

  always_comb begin
    game_state = state_q;
    led        = {state_q, run, lives_thermo(lives)};
  end

endmodule
